// File: rtl/axi_sample_pusher.sv
// Drains a 4-deep queue of PCM samples into an AXI-lite slave as single-beat writes,
// with issue pacing, a B-channel timeout and completion/timeout counters.
module axi_sample_pusher #(
  parameter logic [31:0] BaseAddr      = 32'h41a0_0000,
  parameter int unsigned PaceCycles    = 1,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        maxi_AWVALID,
  input  logic        maxi_AWREADY,
  output logic [31:0] maxi_AWADDR,
  output logic        maxi_WVALID,
  input  logic        maxi_WREADY,
  output logic [31:0] maxi_WDATA,
  input  logic        maxi_BVALID,
  output logic        maxi_BREADY,
  output logic        maxi_ARVALID,
  output logic        maxi_RREADY,
  output logic        busy,
  output logic [31:0] sent_count,
  output logic [15:0] timeout_count,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_e;

  localparam logic [15:0] PaceLoad   = 16'(PaceCycles - 1);
  localparam logic [31:0] TimerLast  = 32'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic [15:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] pace_q, pace_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] sent_q, sent_d;
  logic [15:0] tcount_q, tcount_d;
  logic        tpulse_q, tpulse_d;
  logic        push;
  logic        pop;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign s_ready = (count_q != 3'd4);
  assign push    = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    sent_d    = sent_q;
    tcount_d  = tcount_q;
    tpulse_d  = 1'b0;
    pop       = 1'b0;
    pace_d    = (pace_q != 16'd0) ? pace_q - 16'd1 : pace_q;

    case (state_q)
      IDLE: begin
        if (count_q != 3'd0 && pace_q == 16'd0) begin
          pop       = 1'b1;
          state_d   = ADDR_DATA;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          hold_d    = mem_q[rd_ptr_q];
          pace_d    = PaceLoad;
        end
      end
      ADDR_DATA: begin
        if (awvalid_q && maxi_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && maxi_WREADY)   wvalid_d  = 1'b0;
        // Each channel is done once its valid has dropped or is handshaking now.
        if ((!awvalid_q || maxi_AWREADY) && (!wvalid_q || maxi_WREADY)) begin
          state_d = RESP;
          timer_d = 32'd0;
        end
      end
      RESP: begin
        if (maxi_BVALID) begin
          sent_d  = sent_q + 32'd1;
          state_d = IDLE;
        end else if (timer_q == TimerLast) begin
          tpulse_d = 1'b1;
          if (tcount_q != 16'hFFFF) tcount_d = tcount_q + 16'd1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      hold_q    <= 16'd0;
      pace_q    <= 16'd0;
      timer_q   <= 32'd0;
      sent_q    <= 32'd0;
      tcount_q  <= 16'd0;
      tpulse_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      hold_q    <= hold_d;
      pace_q    <= pace_d;
      timer_q   <= timer_d;
      sent_q    <= sent_d;
      tcount_q  <= tcount_d;
      tpulse_q  <= tpulse_d;
    end
  end

  // Queue storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign maxi_AWVALID  = awvalid_q;
  assign maxi_AWADDR   = BaseAddr;
  assign maxi_WVALID   = wvalid_q;
  assign maxi_WDATA    = {16'h0000, hold_q};
  assign maxi_BREADY   = (state_q == RESP);
  assign maxi_ARVALID  = 1'b0;
  assign maxi_RREADY   = 1'b1;
  assign busy          = (state_q != IDLE);
  assign sent_count    = sent_q;
  assign timeout_count = tcount_q;
  assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_axi_sample_pusher.sv
// Directed bench for axi_sample_pusher: one instance with fast pacing and short timeout,
// a second with PaceCycles = 10 for issue spacing.
module tb_axi_sample_pusher;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        s_ready, awvalid, wvalid, bready, arvalid, rready, busy, tpulse;
  logic [31:0] awaddr, wdata, sent;
  logic [15:0] tcount;

  logic        p_s_valid = 1'b0;
  logic [15:0] p_s_data = 16'd0;
  logic        p_awready = 1'b0, p_wready = 1'b0, p_bvalid = 1'b0;
  logic        p_s_ready, p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready, p_busy, p_tpulse;
  logic [31:0] p_awaddr, p_wdata, p_sent;
  logic [15:0] p_tcount;

  int vectors = 0;
  int errors  = 0;

  always #5 aclk = ~aclk;

  axi_sample_pusher #(.BaseAddr(32'h41a0_0000), .PaceCycles(1), .TimeoutCycles(8)) dut (
    .aclk(aclk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .maxi_AWVALID(awvalid), .maxi_AWREADY(awready), .maxi_AWADDR(awaddr),
    .maxi_WVALID(wvalid), .maxi_WREADY(wready), .maxi_WDATA(wdata),
    .maxi_BVALID(bvalid), .maxi_BREADY(bready), .maxi_ARVALID(arvalid), .maxi_RREADY(rready),
    .busy(busy), .sent_count(sent), .timeout_count(tcount), .timeout_pulse(tpulse)
  );

  axi_sample_pusher #(.BaseAddr(32'h41a0_0000), .PaceCycles(10), .TimeoutCycles(8)) dut_p (
    .aclk(aclk), .areset(areset), .s_valid(p_s_valid), .s_ready(p_s_ready), .s_data(p_s_data),
    .maxi_AWVALID(p_awvalid), .maxi_AWREADY(p_awready), .maxi_AWADDR(p_awaddr),
    .maxi_WVALID(p_wvalid), .maxi_WREADY(p_wready), .maxi_WDATA(p_wdata),
    .maxi_BVALID(p_bvalid), .maxi_BREADY(p_bready), .maxi_ARVALID(p_arvalid), .maxi_RREADY(p_rready),
    .busy(p_busy), .sent_count(p_sent), .timeout_count(p_tcount), .timeout_pulse(p_tpulse)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    if (s_ready !== 1'b1) begin $display("FAIL rst_s_ready: got %0h expected 1", s_ready); errors++; end vectors++;
    if (awvalid !== 1'b0) begin $display("FAIL rst_awvalid: got %0h expected 0", awvalid); errors++; end vectors++;
    if (wvalid !== 1'b0) begin $display("FAIL rst_wvalid: got %0h expected 0", wvalid); errors++; end vectors++;
    if (bready !== 1'b0) begin $display("FAIL rst_bready: got %0h expected 0", bready); errors++; end vectors++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %0h expected 0", busy); errors++; end vectors++;
    if (sent !== 32'd0) begin $display("FAIL rst_sent: got %0h expected 0", sent); errors++; end vectors++;
    if (tcount !== 16'd0) begin $display("FAIL rst_tcount: got %0h expected 0", tcount); errors++; end vectors++;
    if (tpulse !== 1'b0) begin $display("FAIL rst_tpulse: got %0h expected 0", tpulse); errors++; end vectors++;
    if (arvalid !== 1'b0) begin $display("FAIL rst_arvalid: got %0h expected 0", arvalid); errors++; end vectors++;
    if (rready !== 1'b1) begin $display("FAIL rst_rready: got %0h expected 1", rready); errors++; end vectors++;
    if (p_s_ready !== 1'b1) begin $display("FAIL rst_p_s_ready: got %0h expected 1", p_s_ready); errors++; end vectors++;
    areset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    s_valid = 1'b1; s_data = 16'h8001;
    tick();
    s_valid = 1'b0;
    if (awvalid !== 1'b0) begin $display("FAIL sw_latency_early: got %0h expected 0", awvalid); errors++; end vectors++;
    tick();
    if (awvalid !== 1'b1) begin $display("FAIL sw_awvalid: got %0h expected 1", awvalid); errors++; end vectors++;
    if (wvalid !== 1'b1) begin $display("FAIL sw_wvalid: got %0h expected 1", wvalid); errors++; end vectors++;
    if (awaddr !== 32'h41a0_0000) begin $display("FAIL sw_awaddr: got %h expected 41a00000", awaddr); errors++; end vectors++;
    if (wdata !== 32'h0000_8001) begin $display("FAIL sw_wdata: got %h expected 00008001", wdata); errors++; end vectors++;
    if (busy !== 1'b1) begin $display("FAIL sw_busy: got %0h expected 1", busy); errors++; end vectors++;
    if (bready !== 1'b0) begin $display("FAIL sw_bready_ad: got %0h expected 0", bready); errors++; end vectors++;
    tick();
    if (awvalid !== 1'b0 || wvalid !== 1'b0) begin $display("FAIL sw_valids_drop: got aw=%0h w=%0h expected 0 0", awvalid, wvalid); errors++; end vectors++;
    if (bready !== 1'b1) begin $display("FAIL sw_bready_resp: got %0h expected 1", bready); errors++; end vectors++;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    if (sent !== 32'd1) begin $display("FAIL sw_sent: got %0d expected 1", sent); errors++; end vectors++;
    if (busy !== 1'b0 || bready !== 1'b0) begin $display("FAIL sw_idle: got busy=%0h bready=%0h expected 0 0", busy, bready); errors++; end vectors++;
    $display("test_single_write done");
  endtask

  task automatic test_split();
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    s_valid = 1'b1; s_data = 16'h1234;
    tick();
    s_valid = 1'b0;
    tick();
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin $display("FAIL split_issue: got aw=%0h w=%0h expected 1 1", awvalid, wvalid); errors++; end vectors++;
    if (wdata !== 32'h0000_1234) begin $display("FAIL split_wdata: got %h expected 00001234", wdata); errors++; end vectors++;
    tick();
    if (wvalid !== 1'b0 || awvalid !== 1'b1) begin $display("FAIL split_w_first: got aw=%0h w=%0h expected 1 0", awvalid, wvalid); errors++; end vectors++;
    if (bready !== 1'b0) begin $display("FAIL split_bready_ad: got %0h expected 0", bready); errors++; end vectors++;
    wready = 1'b0;
    tick();
    tick();
    if (awvalid !== 1'b1 || busy !== 1'b1) begin $display("FAIL split_aw_hold: got aw=%0h busy=%0h expected 1 1", awvalid, busy); errors++; end vectors++;
    awready = 1'b1;
    tick();
    awready = 1'b0;
    if (awvalid !== 1'b0 || bready !== 1'b1) begin $display("FAIL split_resp: got aw=%0h bready=%0h expected 0 1", awvalid, bready); errors++; end vectors++;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    if (sent !== 32'd2) begin $display("FAIL split_sent: got %0d expected 2", sent); errors++; end vectors++;
    tick();
    tick();
    if (sent !== 32'd2) begin $display("FAIL split_one_b: got %0d expected 2", sent); errors++; end vectors++;
    $display("test_split done");
  endtask

  task automatic test_backpressure();
    logic [15:0] d [6];
    logic [15:0] cap_dat [6];
    int cap_cyc [6];
    int ncap;
    int push_cyc;
    logic pushed;
    d[0] = 16'hA001; d[1] = 16'hB002; d[2] = 16'hC003;
    d[3] = 16'hD004; d[4] = 16'hE005; d[5] = 16'hF006;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = d[i];
      if (s_ready !== 1'b1) begin $display("FAIL bp_accept%0d: got s_ready=%0h expected 1", i, s_ready); errors++; end vectors++;
      tick();
    end
    s_data = d[5];
    if (s_ready !== 1'b0) begin $display("FAIL bp_full: got s_ready=%0h expected 0", s_ready); errors++; end vectors++;
    tick();
    tick();
    if (s_ready !== 1'b0 || awvalid !== 1'b1) begin $display("FAIL bp_stall: got s_ready=%0h aw=%0h expected 0 1", s_ready, awvalid); errors++; end vectors++;
    awready = 1'b1; bvalid = 1'b1;
    ncap = 0; push_cyc = -1; pushed = 1'b0;
    for (int c = 0; c < 60 && ncap < 6; c++) begin
      if (awvalid) begin cap_dat[ncap] = wdata[15:0]; cap_cyc[ncap] = c; ncap++; end
      if (s_valid && s_ready && !pushed) begin push_cyc = c; pushed = 1'b1; end
      tick();
      if (pushed) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    if (ncap !== 6) begin $display("FAIL bp_count: got %0d writes expected 6", ncap); errors++; end vectors++;
    for (int k = 0; k < ncap; k++) begin
      if (cap_dat[k] !== d[k]) begin $display("FAIL bp_order%0d: got %h expected %h", k, cap_dat[k], d[k]); errors++; end vectors++;
      if (k > 0) begin
        if (cap_cyc[k] - cap_cyc[k-1] !== 3) begin $display("FAIL bp_spacing%0d: got %0d expected 3", k, cap_cyc[k] - cap_cyc[k-1]); errors++; end vectors++;
      end
    end
    if (ncap > 1) begin
      if (push_cyc !== cap_cyc[1]) begin $display("FAIL bp_ready_rise: got cycle %0d expected %0d", push_cyc, cap_cyc[1]); errors++; end vectors++;
    end
    tick();
    bvalid = 1'b0;
    if (sent !== 32'd8 || busy !== 1'b0) begin $display("FAIL bp_sent: got sent=%0d busy=%0h expected 8 0", sent, busy); errors++; end vectors++;
    $display("test_backpressure done");
  endtask

  task automatic test_timeout();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    s_valid = 1'b1; s_data = 16'h0AAA;
    tick();
    s_data = 16'h0BBB;
    tick();
    s_valid = 1'b0;
    if (wdata !== 32'h0000_0AAA) begin $display("FAIL to_wdata_a: got %h expected 00000aaa", wdata); errors++; end vectors++;
    tick();
    if (bready !== 1'b1) begin $display("FAIL to_resp_entry: got bready=%0h expected 1", bready); errors++; end vectors++;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (tpulse !== 1'b0 || busy !== 1'b1) begin $display("FAIL to_early%0d: got pulse=%0h busy=%0h expected 0 1", k, tpulse, busy); errors++; end vectors++;
    end
    tick();
    if (tpulse !== 1'b1) begin $display("FAIL to_pulse: got %0h expected 1", tpulse); errors++; end vectors++;
    if (tcount !== 16'd1 || busy !== 1'b0) begin $display("FAIL to_count: got tcount=%0d busy=%0h expected 1 0", tcount, busy); errors++; end vectors++;
    tick();
    if (tpulse !== 1'b0) begin $display("FAIL to_pulse_width: got %0h expected 0", tpulse); errors++; end vectors++;
    if (awvalid !== 1'b1 || wdata !== 32'h0000_0BBB) begin $display("FAIL to_next_issue: got aw=%0h wdata=%h expected 1 00000bbb", awvalid, wdata); errors++; end vectors++;
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    if (sent !== 32'd9 || tcount !== 16'd1) begin $display("FAIL to_after: got sent=%0d tcount=%0d expected 9 1", sent, tcount); errors++; end vectors++;
    $display("test_timeout done");
  endtask

  task automatic test_reset_in_resp();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    s_valid = 1'b1; s_data = 16'h5555;
    tick();
    s_data = 16'h6666;
    tick();
    s_valid = 1'b0;
    tick();
    if (bready !== 1'b1) begin $display("FAIL rr_in_resp: got bready=%0h expected 1", bready); errors++; end vectors++;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    if (busy !== 1'b0 || bready !== 1'b0) begin $display("FAIL rr_state: got busy=%0h bready=%0h expected 0 0", busy, bready); errors++; end vectors++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0) begin $display("FAIL rr_valids: got aw=%0h w=%0h expected 0 0", awvalid, wvalid); errors++; end vectors++;
    if (s_ready !== 1'b1) begin $display("FAIL rr_s_ready: got %0h expected 1", s_ready); errors++; end vectors++;
    if (sent !== 32'd0 || tcount !== 16'd0 || tpulse !== 1'b0) begin $display("FAIL rr_counters: got sent=%0d tcount=%0d pulse=%0h expected 0 0 0", sent, tcount, tpulse); errors++; end vectors++;
    bvalid = 1'b1;
    tick();
    tick();
    bvalid = 1'b0;
    if (sent !== 32'd0) begin $display("FAIL rr_b_ignored: got sent=%0d expected 0", sent); errors++; end vectors++;
    if (awvalid !== 1'b0 || busy !== 1'b0) begin $display("FAIL rr_queue_flushed: got aw=%0h busy=%0h expected 0 0", awvalid, busy); errors++; end vectors++;
    $display("test_reset_in_resp done");
  endtask

  task automatic test_pacing();
    logic [15:0] pd [3];
    int rise_cyc [3];
    logic [15:0] rise_dat [3];
    int nrise;
    logic prev;
    pd[0] = 16'h0101; pd[1] = 16'h0202; pd[2] = 16'h0303;
    p_awready = 1'b1; p_wready = 1'b1; p_bvalid = 1'b1;
    nrise = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i < 3) begin p_s_valid = 1'b1; p_s_data = pd[i]; end
      else p_s_valid = 1'b0;
      tick();
      if (p_awvalid && !prev) begin
        if (nrise < 3) begin rise_cyc[nrise] = i; rise_dat[nrise] = p_wdata[15:0]; end
        nrise++;
      end
      prev = p_awvalid;
    end
    p_bvalid = 1'b0;
    if (nrise !== 3) begin $display("FAIL pace_rises: got %0d expected 3", nrise); errors++; end vectors++;
    for (int k = 0; k < 3 && k < nrise; k++) begin
      if (rise_dat[k] !== pd[k]) begin $display("FAIL pace_order%0d: got %h expected %h", k, rise_dat[k], pd[k]); errors++; end vectors++;
      if (k > 0) begin
        if (rise_cyc[k] - rise_cyc[k-1] !== 10) begin $display("FAIL pace_gap%0d: got %0d expected 10", k, rise_cyc[k] - rise_cyc[k-1]); errors++; end vectors++;
      end
    end
    if (p_sent !== 32'd3) begin $display("FAIL pace_sent: got %0d expected 3", p_sent); errors++; end vectors++;
    $display("test_pacing done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_split();
    test_backpressure();
    test_timeout();
    test_reset_in_resp();
    test_pacing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
